// File: rtl/servo_arbiter.sv
// servo_arbiter: round-robin sharing of one pen-lift servo controller between NUM_REQ requesters.
// Optional feature macro SERVO_ARB_SKIP_REDUNDANT_EN: skip the servo handshake when the target equals the last reached position.
module servo_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int POS_W   = 1,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk_en,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*POS_W-1:0] req_pos,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic [ID_W-1:0]          grant_id,
    output logic                     srv_trigger,
    output logic [POS_W-1:0]         srv_pos,
    input  logic                     srv_rdy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
    localparam logic [ID_W:0]      NUM_EXT  = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0]    LAST_ID  = ID_W'(NUM_REQ-1);

    state_t           state_reg;
    logic [ID_W-1:0]  rr_reg;
    logic [POS_W-1:0] pos_arr [NUM_REQ];
    logic [ID_W-1:0]  pick;
    logic             found;
    logic [ID_W:0]    idx;
    logic [POS_W-1:0] pick_pos;
    logic [ID_W-1:0]  rr_next;
    logic             skip;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pos
        assign pos_arr[gi] = req_pos[gi*POS_W +: POS_W];
    end

    // Walk offsets from the highest down so the requester closest to rr_reg wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_reg} + (ID_W+1)'(k);
            if (idx >= NUM_EXT) begin
                idx = idx - NUM_EXT;
            end
            if (req[idx[ID_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[ID_W-1:0];
            end
        end
    end

    assign pick_pos = pos_arr[pick];
    assign rr_next  = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

`ifdef SERVO_ARB_SKIP_REDUNDANT_EN
    logic [POS_W-1:0] cur_pos_reg;
    logic             pos_valid_reg;

    assign skip = pos_valid_reg && (pick_pos == cur_pos_reg);

    // Position the servo last reported reaching; cleared by reset so the first move is never skipped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_pos_reg   <= '0;
            pos_valid_reg <= 1'b0;
        end else if (clk_en && state_reg == WAIT && srv_rdy) begin
            cur_pos_reg   <= srv_pos;
            pos_valid_reg <= 1'b1;
        end
    end
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            rr_reg      <= '0;
            done        <= '0;
            busy        <= 1'b0;
            grant_id    <= '0;
            srv_trigger <= 1'b0;
            srv_pos     <= '0;
        end else if (clk_en) begin
            case (state_reg)
                IDLE: begin
                    if (srv_rdy && found) begin
                        grant_id <= pick;
                        srv_pos  <= pick_pos;
                        busy     <= 1'b1;
                        if (skip) begin
                            done      <= ONE_HOT0 << pick;
                            state_reg <= DONE;
                        end else begin
                            srv_trigger <= 1'b1;
                            state_reg   <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (!srv_rdy) begin
                        srv_trigger <= 1'b0;
                        state_reg   <= WAIT;
                    end
                end
                WAIT: begin
                    if (srv_rdy) begin
                        done      <= ONE_HOT0 << grant_id;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done      <= '0;
                    busy      <= 1'b0;
                    rr_reg    <= rr_next;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_servo_arbiter.sv
// tb_servo_arbiter: directed stimulus for servo_arbiter; the bench plays the servo controller by hand.
module tb_servo_arbiter;
    localparam int NUM_REQ = 2;
    localparam int POS_W   = 1;

    logic                     clk;
    logic                     reset;
    logic                     clk_en;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*POS_W-1:0] req_pos;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;
    logic [0:0]               grant_id;
    logic                     srv_trigger;
    logic [POS_W-1:0]         srv_pos;
    logic                     srv_rdy;

    int n_checks = 0;
    int n_fail   = 0;
    bit skip_build;

    logic e_busy, e_trig;
    logic [NUM_REQ-1:0] e_done;

    servo_arbiter #(.NUM_REQ(NUM_REQ), .POS_W(POS_W)) dut (
        .clk(clk),
        .reset(reset),
        .clk_en(clk_en),
        .req(req),
        .req_pos(req_pos),
        .done(done),
        .busy(busy),
        .grant_id(grant_id),
        .srv_trigger(srv_trigger),
        .srv_pos(srv_pos),
        .srv_rdy(srv_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete service starting from IDLE with req/req_pos already applied.
    task automatic move(input int id, input logic [POS_W-1:0] pos, input int hold, input bit skip);
        logic [NUM_REQ*POS_W-1:0] saved;
        step();
        chk("grant_busy", 32'(busy), 32'd1);
        chk("grant_id", 32'(grant_id), 32'(id));
        chk("grant_pos", 32'(srv_pos), 32'(pos));
        if (skip) begin
            chk("skip_trig", 32'(srv_trigger), 32'd0);
            chk("skip_done", 32'(done), 32'd1 << id);
        end else begin
            chk("issue_trig", 32'(srv_trigger), 32'd1);
            chk("issue_done", 32'(done), 32'd0);
            saved   = req_pos;
            req_pos = ~req_pos;
            srv_rdy = 1'b0;
            for (int i = 0; i < hold; i++) begin
                step();
                chk("wait_trig", 32'(srv_trigger), 32'd0);
                chk("wait_busy", 32'(busy), 32'd1);
                chk("wait_done", 32'(done), 32'd0);
                chk("wait_pos_stable", 32'(srv_pos), 32'(pos));
            end
            req_pos = saved;
            srv_rdy = 1'b1;
            step();
            chk("done_pulse", 32'(done), 32'd1 << id);
            chk("done_busy", 32'(busy), 32'd1);
            chk("done_trig", 32'(srv_trigger), 32'd0);
            chk("done_pos", 32'(srv_pos), 32'(pos));
        end
    endtask

    task automatic idle_chk(input string tag);
        step();
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_trig"}, 32'(srv_trigger), 32'd0);
    endtask

    // Three clk_en-low cycles (outputs must hold) then one enabled cycle.
    task automatic slow_step(input logic b, input logic t, input logic [NUM_REQ-1:0] d);
        for (int i = 0; i < 3; i++) begin
            clk_en = 1'b0;
            step();
            chk("hold_busy", 32'(busy), 32'(e_busy));
            chk("hold_trig", 32'(srv_trigger), 32'(e_trig));
            chk("hold_done", 32'(done), 32'(e_done));
        end
        clk_en = 1'b1;
        step();
        e_busy = b;
        e_trig = t;
        e_done = d;
        chk("slow_busy", 32'(busy), 32'(e_busy));
        chk("slow_trig", 32'(srv_trigger), 32'(e_trig));
        chk("slow_done", 32'(done), 32'(e_done));
    endtask

    initial begin
`ifdef SERVO_ARB_SKIP_REDUNDANT_EN
        skip_build = 1'b1;
`else
        skip_build = 1'b0;
`endif
        reset   = 1'b0;
        clk_en  = 1'b1;
        req     = '0;
        req_pos = '0;
        srv_rdy = 1'b1;

        // Reset state
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        chk("rst_trig", 32'(srv_trigger), 32'd0);
        chk("rst_pos", 32'(srv_pos), 32'd0);
        reset = 1'b1;
        idle_chk("idle_noreq");

        // Single requester, pos0 = UP, servo busy 10 cycles
        req     = 2'b01;
        req_pos = 2'b01;
        move(0, 1'b1, 10, 1'b0);
        req = 2'b00;
        idle_chk("t1_idle");

        // Same requester, same position again
        req = 2'b01;
        move(0, 1'b1, 3, skip_build);
        req = 2'b00;
        idle_chk("t3_idle");

        // Reset asserted while waiting on the servo
        req     = 2'b10;
        req_pos = 2'b00;
        step();
        chk("t5_grant_id", 32'(grant_id), 32'd1);
        chk("t5_trig", 32'(srv_trigger), 32'd1);
        srv_rdy = 1'b0;
        step();
        step();
        chk("t5_wait_busy", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("t5_async_trig", 32'(srv_trigger), 32'd0);
        chk("t5_async_busy", 32'(busy), 32'd0);
        chk("t5_async_done", 32'(done), 32'd0);
        chk("t5_async_gid", 32'(grant_id), 32'd0);
        step();
        reset   = 1'b1;
        srv_rdy = 1'b1;
        req     = 2'b00;
        idle_chk("t5_idle");

        // Both requesting with rr=0: 0, 1, 0 with an idle cycle between; never skipped after reset
        req     = 2'b11;
        req_pos = 2'b01;
        move(0, 1'b1, 3, 1'b0);
        idle_chk("t2_gap1");
        move(1, 1'b0, 2, 1'b0);
        idle_chk("t2_gap2");
        move(0, 1'b1, 2, 1'b0);
        req = 2'b00;
        idle_chk("t2_idle");

        // clk_en high one cycle in four during a move
        req     = 2'b10;
        req_pos = 2'b00;
        e_busy  = 1'b0;
        e_trig  = 1'b0;
        e_done  = '0;
        slow_step(1'b1, 1'b1, 2'b00);
        chk("t6_gid", 32'(grant_id), 32'd1);
        srv_rdy = 1'b0;
        slow_step(1'b1, 1'b0, 2'b00);
        srv_rdy = 1'b1;
        slow_step(1'b1, 1'b0, 2'b10);
        req = 2'b00;
        slow_step(1'b0, 1'b0, 2'b00);

        // srv_rdy low at reset release: no grant until it rises
        reset   = 1'b0;
        srv_rdy = 1'b0;
        req     = 2'b10;
        req_pos = 2'b10;
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_busy", 32'(busy), 32'd0);
            chk("t4_trig", 32'(srv_trigger), 32'd0);
            chk("t4_gid", 32'(grant_id), 32'd0);
        end
        srv_rdy = 1'b1;
        move(1, 1'b1, 2, 1'b0);
        req = 2'b00;
        idle_chk("t4_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
